data_pack: RTL and testbench
============================

# data_pack

Packs a stream of LSB-first 7-bit values back into LSB-aligned 32-bit words with packet framing. It sits directly downstream of `data_unpack`, accepting that block's non-backpressured `valid/data/sop/eop` value stream. It presents 32-bit words through a ready/valid output port, with an internal FIFO absorbing downstream stalls.

## Interface
- `FIFO_DEPTH`, 8, output word FIFO entries; power of two, ≥4.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid_in` input 1: a value is presented this cycle; always accepted (no input backpressure).
- `data_in` input 7: value; only bits of valid cycles are used.
- `sop_in` input 1: first value of a packet.
- `eop_in` input 1: last value of a packet.
- `valid_out` output 1: a word is presented.
- `data_out` output 32: packed word.
- `sop_out` output 1: first word of a packet; qualified by `valid_out`.
- `eop_out` output 1: last word of a packet; qualified by `valid_out`.
- `ready_in` input 1: downstream accepts the word when `valid_out && ready_in`.
- `ovf_out` output 1: sticky; words were dropped because the FIFO was full.
- `err_out` output 1: sticky; `sop_in` arrived while a packet was open.

## Operation
- States:
  - IDLE: valid values without `sop_in` are discarded.
  - IN_PKT: a packet is open.
  - IDLE→IN_PKT on `valid_in && sop_in && !eop_in`.
  - IN_PKT→IDLE on `valid_in && eop_in`.
- Accumulator: 38-bit `acc`, fill count `nbits` (0..31).
- Accepted value: `acc |= data_in << nbits`; `nbits += 7`.
- If the result is ≥32: write `acc[31:0]`, shift `acc` right 32, `nbits -= 32`.
- Bit order: value k occupies stream bits [7k+6:7k]; bit 0 of the first value is `data_out[0]` of the first word.
- eop: after any full-word write, if `nbits > 0`, write the residual word with the upper bits zeroed. `acc` and `nbits` then clear to 0.
- A single cycle can therefore write two words (full + residual). The FIFO write port takes 0, 1 or 2 words per cycle, in order.
- `sop_out` is set on the first word written after sop. `eop_out` is set on the last word of the packet. Both may be set on one word (packet ≤4 values).
- `sop_in` with `eop_in` in IDLE: a one-value packet, giving one word with `sop_out` and `eop_out` both set. The state remains IDLE.
- `sop_in` in IN_PKT: the residual `acc` is discarded and `err_out` is set. A new packet starts at `nbits=0`. Words already written keep no `eop_out`.
- Overflow: if free entries < words to write this cycle, nothing from that cycle is written and `ovf_out` is set. Accumulator update proceeds as if the words were written.
- FIFO read and write in the same cycle count the read first, so the freed entry is usable.

## Timing
- Reset: `valid_out`, `sop_out`, `eop_out`, `ovf_out` and `err_out` = 0; `data_out` = 0. FIFO is empty, `acc`=0, `nbits`=0, state IDLE.
- Reset mid-packet drops all state and FIFO contents; the next sop is handled cleanly.
- Latency: a word completed by the value in cycle N shows `valid_out` in cycle N+1 if the FIFO was empty.
- `data_out`, `sop_out` and `eop_out` are held stable while `valid_out && !ready_in`.
- With `ready_in` held high and a continuous input, each word appears once every 4–5 value cycles, and the FIFO never exceeds 2 entries.
- Back-to-back packets: the eop cycle and the next sop cycle may be adjacent, with no dead input cycle required.

## Configuration
- `DATA_PACK_OVF_CNT_EN`:
  - Defined: adds output port `ovf_count` [15:0]. It counts dropped words (+1 or +2 per overflow cycle), saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and counter are absent; only the sticky `ovf_out` exists.

## Test plan
- Packet of 32 values 0..31 with `ready_in`=1 → 7 words (224 bits). The first word is `{data bits}` with `sop_out` set; `eop_out` is set on word 7 only; no residual word.
- Packet of 5 values of 7'h7F → word0 = 32'hFFFF_FFFF (`sop_out`); word1 = 32'h0000_0007 (`eop_out`). Both words are written in the eop cycle.
- 3 values of 7'h55 before any sop, then a sop+eop value 7'h2A → the first 3 are discarded; a single word 32'h0000_002A with `sop_out`=`eop_out`=1.
- Hold `ready_in`=0 through 40 continuous packed words with `FIFO_DEPTH`=8 → exactly 8 words are retained, `ovf_out`=1, and `ovf_count` = dropped count when the macro is enabled. The retained words then drain in order.
- `sop_in` after 3 values of an open packet → `err_out`=1; the next words carry only the new packet's bits, starting at bit 0.
- Assert `rst` for 1 cycle mid-packet with FIFO entries pending → `valid_out`=0 in the following cycle, and a fresh 5-value packet then reproduces the words of the second scenario.

Source files
------------

// File: rtl/data_pack.sv
// data_pack: repacks an LSB-first 7-bit value stream into LSB-aligned 32-bit words
// with sop/eop framing, buffered by a word FIFO. Define DATA_PACK_OVF_CNT_EN to add ovf_count.
module data_pack #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  data_in,
  input  logic        sop_in,
  input  logic        eop_in,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        sop_out,
  output logic        eop_out,
  input  logic        ready_in,
  output logic        ovf_out,
  output logic        err_out
`ifdef DATA_PACK_OVF_CNT_EN
  ,
  output logic [15:0] ovf_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } word_t;

  state_t      state_q, state_d;
  logic [37:0] acc_q, acc_d;
  logic [4:0]  nbits_q, nbits_d;
  logic        first_q, first_d;

  logic        accept, restart, close, bad_sop;

  logic [37:0] base_acc, sum_acc, rem_acc;
  logic [5:0]  base_n, sum_n, rem_n;
  logic        full, resid, first_cur;
  logic [1:0]  nwr;
  word_t       w0, w1;

  word_t          mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, free;
  logic           rd, ovf_now, wr_en;
  logic           ovf_q, err_q;
  word_t          head;

  // ---------------------------------------------------------------------------
  // Packet framing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb assigns defaults first so no path leaves a signal
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    if (valid_in) begin
      if (state_q == IDLE) begin
        if (sop_in && !eop_in) state_d = IN_PKT;
      end else begin
        if (eop_in) state_d = IDLE;
      end
    end
  end

  always_comb begin
    accept  = valid_in && ((state_q == IN_PKT) || sop_in);
    restart = accept && sop_in;
    close   = accept && eop_in;
    bad_sop = valid_in && sop_in && (state_q == IN_PKT);
  end

  // ---------------------------------------------------------------------------
  // Accumulator: a sop restarts from an empty accumulator, dropping any residue.
  // Bits above nbits are always zero, so the residual word needs no masking.
  // ---------------------------------------------------------------------------
  always_comb begin
    base_acc  = restart ? 38'd0 : acc_q;
    base_n    = restart ? 6'd0 : {1'b0, nbits_q};
    sum_acc   = base_acc | ({31'd0, data_in} << base_n);
    sum_n     = base_n + 6'd7;
    full      = (sum_n >= 6'd32);
    rem_acc   = full ? (sum_acc >> 32) : sum_acc;
    rem_n     = full ? (sum_n - 6'd32) : sum_n;
    resid     = close && (rem_n != 6'd0);
    nwr       = accept ? ({1'b0, full} + {1'b0, resid}) : 2'd0;
    first_cur = restart | first_q;

    // w0 is the full word, or the residual alone when no full word completed.
    w0 = '{sop: first_cur, eop: close && (nwr == 2'd1), data: sum_acc[31:0]};
    w1 = '{sop: 1'b0, eop: close, data: rem_acc[31:0]};

    acc_d   = acc_q;
    nbits_d = nbits_q;
    first_d = first_q;
    if (accept) begin
      if (close) begin
        acc_d   = 38'd0;
        nbits_d = 5'd0;
      end else begin
        acc_d   = rem_acc;
        nbits_d = rem_n[4:0];
      end
      first_d = (nwr != 2'd0) ? 1'b0 : first_cur;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= 38'd0;
      nbits_q <= 5'd0;
      first_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      nbits_q <= nbits_d;
      first_q <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO: up to two writes per cycle; a same-cycle read frees its entry first.
  // ---------------------------------------------------------------------------
  assign head = mem[rd_ptr_q];
  assign rd   = valid_out && ready_in;

  always_comb begin
    free    = CW'(FIFO_DEPTH) - count_q + CW'(rd);
    ovf_now = (CW'(nwr) > free);
    wr_en   = (nwr != 2'd0) && !ovf_now;
  end

  // NOTE: the storage array has no reset; count_q alone defines which entries
  // are meaningful, and unoccupied entries are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= w0;
      if (nwr == 2'd2) mem[wr_ptr_q + AW'(1)] <= w1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (rd)    rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(nwr);
      count_q <= count_q - CW'(rd) + (wr_en ? CW'(nwr) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (ovf_now) ovf_q <= 1'b1;
      if (bad_sop) err_q <= 1'b1;
    end
  end

`ifdef DATA_PACK_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;
  logic [16:0] ovf_sum;

  assign ovf_sum = {1'b0, ovf_cnt_q} + 17'(nwr);

  always_ff @(posedge clk) begin
    if (rst)          ovf_cnt_q <= 16'd0;
    else if (ovf_now) ovf_cnt_q <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  assign ovf_count = ovf_cnt_q;
`endif

  // Outputs read straight from the head entry, so they stay stable under a stall.
  assign valid_out = (count_q != '0);
  assign data_out  = valid_out ? head.data : 32'd0;
  assign sop_out   = valid_out && head.sop;
  assign eop_out   = valid_out && head.eop;
  assign ovf_out   = ovf_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_data_pack.sv
// Bench for data_pack: constant vector table, directed corner sequences and random
// traffic checked against a bit-queue reference model of the packing rules.
module tb_data_pack;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [6:0]  data_in;
  logic        sop_in;
  logic        eop_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        ovf_out;
  logic        err_out;
`ifdef DATA_PACK_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  data_pack #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .ready_in  (ready_in),
    .ovf_out   (ovf_out),
    .err_out   (err_out)
`ifdef DATA_PACK_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of stream bits per packet and a queue of words.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    bit          sop;
    bit          eop;
  } mword_t;

  mword_t      m_fifo[$];
  bit          m_bits[$];
  bit          m_open, m_first, m_ovf, m_err;
  int          m_dropped;
  logic [31:0] got[$];

  typedef struct packed {
    logic        v;
    logic [6:0]  d;
    logic        s;
    logic        e;
    logic        xv;
    logic [31:0] xd;
    logic        xs;
    logic        xe;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic v, input logic [6:0] d, input logic s, input logic e,
                              input logic xv, input logic [31:0] xd, input logic xs, input logic xe);
    vec_t r;
    r = '{v: v, d: d, s: s, e: e, xv: xv, xd: xd, xs: xs, xe: xe};
    return r;
  endfunction

  function automatic logic [15:0] sat16(input int x);
    return (x > 65535) ? 16'hFFFF : 16'(x);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_bits.delete();
    m_open    = 0;
    m_first   = 0;
    m_ovf     = 0;
    m_err     = 0;
    m_dropped = 0;
  endtask

  task automatic model_update(input bit v, input logic [6:0] d, input bit s, input bit e,
                              input bit rd);
    mword_t prod[$];
    mword_t w;
    if (rd) void'(m_fifo.pop_front());
    if (v && (m_open || s)) begin
      if (s) begin
        if (m_open) m_err = 1;
        m_bits.delete();
        m_first = 1;
      end
      for (int i = 0; i < 7; i++) m_bits.push_back(d[i]);
      if (m_bits.size() >= 32) begin
        w.data = '0;
        for (int i = 0; i < 32; i++) w.data[i] = m_bits.pop_front();
        w.sop = m_first;
        w.eop = 0;
        m_first = 0;
        prod.push_back(w);
      end
      if (e) begin
        if (m_bits.size() > 0) begin
          w.data = '0;
          for (int i = 0; i < m_bits.size(); i++) w.data[i] = m_bits[i];
          w.sop = m_first;
          w.eop = 0;
          m_first = 0;
          prod.push_back(w);
          m_bits.delete();
        end
        if (prod.size() > 0) prod[prod.size()-1].eop = 1;
      end
      m_open = !e;
    end
    if (m_fifo.size() + prod.size() > DEPTH) begin
      m_ovf = 1;
      m_dropped += prod.size();
    end else begin
      foreach (prod[i]) m_fifo.push_back(prod[i]);
    end
  endtask

  task automatic check_outputs();
    check("valid_out", 64'(valid_out), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0)
      check("word", {sop_out, eop_out, data_out},
            {m_fifo[0].sop, m_fifo[0].eop, m_fifo[0].data});
    check("ovf_err", {ovf_out, err_out}, {m_ovf, m_err});
`ifdef DATA_PACK_OVF_CNT_EN
    check("ovf_count", 64'(ovf_count), 64'(sat16(m_dropped)));
`endif
  endtask

  // One input cycle: compare against the model, then advance the model past the edge.
  task automatic step(input bit v, input logic [6:0] d, input bit s, input bit e, input bit r);
    bit rd;
    valid_in = v;
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    ready_in = r;
    #1;
    check_outputs();
    rd = r && (m_fifo.size() > 0);
    if (valid_out && ready_in) got.push_back(data_out);
    @(posedge clk);
    model_update(v, d, s, e, rd);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 7'd0, 0, 0, r);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 7'd0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    got.delete();
  endtask

  task automatic send_7f_packet();
    for (int i = 0; i < 5; i++) step(1, 7'h7F, i == 0, i == 4, 1);
    idle(4, 1);
  endtask

  initial begin
    rst      = 1'b1;
    ready_in = 1'b0;
    tbl[0]  = mk(1, 7'h7F, 1, 0, 0, 32'h0,         0, 0);
    tbl[1]  = mk(1, 7'h7F, 0, 0, 0, 32'h0,         0, 0);
    tbl[2]  = mk(1, 7'h7F, 0, 0, 0, 32'h0,         0, 0);
    tbl[3]  = mk(1, 7'h7F, 0, 0, 0, 32'h0,         0, 0);
    tbl[4]  = mk(1, 7'h7F, 0, 1, 1, 32'hFFFF_FFFF, 1, 0);
    tbl[5]  = mk(0, 7'h00, 0, 0, 1, 32'h0000_0007, 0, 1);
    tbl[6]  = mk(0, 7'h00, 0, 0, 0, 32'h0,         0, 0);
    tbl[7]  = mk(1, 7'h55, 0, 0, 0, 32'h0,         0, 0);
    tbl[8]  = mk(1, 7'h55, 0, 0, 0, 32'h0,         0, 0);
    tbl[9]  = mk(1, 7'h55, 0, 0, 0, 32'h0,         0, 0);
    tbl[10] = mk(1, 7'h2A, 1, 1, 1, 32'h0000_002A, 1, 1);
    tbl[11] = mk(0, 7'h00, 0, 0, 0, 32'h0,         0, 0);

    do_reset();
    check("reset_state", {valid_out, sop_out, eop_out, ovf_out, err_out, data_out}, 64'd0);

    // Constant vectors: 5 x 7F packet, then discarded values and a one-value packet.
    ready_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      valid_in = tbl[i].v;
      data_in  = tbl[i].d;
      sop_in   = tbl[i].s;
      eop_in   = tbl[i].e;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i), 64'(valid_out), 64'(tbl[i].xv));
      if (tbl[i].xv)
        check($sformatf("tbl%0d_word", i), {sop_out, eop_out, data_out},
              {tbl[i].xs, tbl[i].xe, tbl[i].xd});
    end

    // 32 values 0..31: exactly 7 words, no residual.
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 7'(i), i == 0, i == 31, 1);
    idle(4, 1);
    check("s1_words", 64'(got.size()), 64'd7);
    check("s1_word0", 64'((got.size() > 0) ? got[0] : 32'hDEAD_BEEF), 64'h4060_8080);

    // Stall through 40 words: 8 retained, 32 dropped, drained in order.
    do_reset();
    for (int i = 0; i < 182; i++) step(1, 7'(i * 5 + 3), i == 0, i == 181, 0);
    check("ovf_sticky", 64'(ovf_out), 64'd1);
`ifdef DATA_PACK_OVF_CNT_EN
    check("ovf_count_32", 64'(ovf_count), 64'd32);
`endif
    idle(12, 1);
    check("ovf_retained", 64'(got.size()), 64'd8);

    // sop while a packet is open: residue discarded, new packet starts at bit 0.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 7'(7'h11 + i), i == 0, 0, 1);
    send_7f_packet();
    check("err_sticky", 64'(err_out), 64'd1);
    check("err_words", 64'(got.size()), 64'd2);
    check("err_word0", 64'((got.size() > 0) ? got[0] : 32'h0), 64'hFFFF_FFFF);
    check("err_word1", 64'((got.size() > 1) ? got[1] : 32'h0), 64'h0000_0007);

    // Reset mid-packet with FIFO entries pending.
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 7'(i + 40), i == 0, 0, 0);
    check("pending_before_rst", 64'(valid_out), 64'd1);
    do_reset();
    check("valid_after_rst", 64'(valid_out), 64'd0);
    send_7f_packet();
    check("rst_words", 64'(got.size()), 64'd2);
    check("rst_word0", 64'((got.size() > 0) ? got[0] : 32'h0), 64'hFFFF_FFFF);
    check("rst_word1", 64'((got.size() > 1) ? got[1] : 32'h0), 64'h0000_0007);

    // Random traffic: bursts, stalls, stray values, nested sops.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v, s, e, r;
      v = ($urandom % 4) != 0;
      if (m_open) begin
        s = ($urandom % 40) == 0;
        e = ($urandom % 12) == 0;
      end else begin
        s = ($urandom % 3) == 0;
        e = s && (($urandom % 6) == 0);
      end
      r = ((i / 200) % 3 == 2) ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
      step(v, 7'($urandom), s, e, r);
    end
    idle(DEPTH + 4, 1);
    check("final_empty", 64'(valid_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
